// File: rtl/store_unit.sv
// store_unit: uPOWER byte/half/word/doubleword store with split-beat memory writes
module store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        store_valid,
  output logic        store_ready,
  input  logic [5:0]  opcode,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_ack,
  output logic        store_done,
  output logic        store_err
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  state_t state, state_nx;
  logic [5:0]   op_q;
  logic [63:0]  addr_q, data_q, base, data_mask;
  logic [3:0]   nb;
  logic [2:0]   off;
  logic [7:0]   lane_mask;
  logic [127:0] img_d;
  logic [15:0]  img_m;
  logic         split, accept, legal, last_ack;

  function automatic logic [3:0] op_bytes(input logic [5:0] op);
    return op == 6'd38 ? 4'd1 : op == 6'd44 ? 4'd2 : op == 6'd36 ? 4'd4 : op == 6'd62 ? 4'd8 : 4'd0;
  endfunction

  assign accept    = store_valid && store_ready;
  assign legal     = op_bytes(opcode) != 4'd0;
  assign nb        = op_bytes(op_q);
  assign off       = addr_q[2:0];
  assign base      = {addr_q[63:3], 3'b000};
  assign lane_mask = 8'hFF >> (4'd8 - nb);
  assign data_mask = 64'hFFFF_FFFF_FFFF_FFFF >> (7'd64 - {nb, 3'b000});
  assign img_d     = {64'd0, data_q & data_mask} << {off, 3'b000};
  assign img_m     = {8'd0, lane_mask} << off;
  assign split     = ({1'b0, off} + nb) > 4'd8;
  assign last_ack  = mem_ack && ((state == BEAT0 && !split) || state == BEAT1);

  // state register, request latch and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      store_done <= 1'b0;
      store_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      store_done <= last_ack;
      store_err  <= accept && !legal;
      if (accept) begin
        op_q   <= opcode;
        addr_q <= addr;
        data_q <= store_data;
      end
    end
  end

  // next state: illegal opcodes never leave IDLE; second beat only when the store crosses a doubleword
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept && legal ? BEAT0 : IDLE;
      BEAT0:   state_nx = mem_ack ? (split ? BEAT1 : IDLE) : BEAT0;
      BEAT1:   state_nx = mem_ack ? IDLE : BEAT1;
      default: state_nx = IDLE;
    endcase
  end

  // beat outputs decoded from state so they hold steady until ack and read zero when idle
  always_comb begin
    store_ready = state == IDLE;
    mem_req     = state != IDLE;
    mem_addr    = state == BEAT0 ? base : state == BEAT1 ? base + 64'd8 : 64'd0;
    mem_wdata   = state == BEAT0 ? img_d[63:0] : state == BEAT1 ? img_d[127:64] : 64'd0;
    mem_be      = state == BEAT0 ? img_m[7:0] : state == BEAT1 ? img_m[15:8] : 8'd0;
  end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed vectors for store_unit
module tb_store_unit;
  logic        clk = 0, rst_n = 0, store_valid = 0, mem_ack = 0;
  logic [5:0]  opcode = 0;
  logic [63:0] addr = 0, store_data = 0;
  logic        store_ready, mem_req, store_done, store_err;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_be;
  int          vecs = 0, errs = 0;

  store_unit dut (
    .clk(clk), .rst_n(rst_n), .store_valid(store_valid), .store_ready(store_ready),
    .opcode(opcode), .addr(addr), .store_data(store_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .store_done(store_done), .store_err(store_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // present a request at the current negedge; returns one cycle after acceptance
  task automatic issue(input logic [5:0] op, input logic [63:0] a, input logic [63:0] d);
    store_valid = 1; opcode = op; addr = a; store_data = d;
    @(negedge clk);
    store_valid = 0; opcode = 6'd0; addr = '1; store_data = '1;
  endtask

  // check a beat for dly waiting cycles plus the ack cycle, then ack it
  task automatic beat(input string tag, input logic [63:0] ea, input logic [7:0] ebe, input logic [63:0] ed, input int dly);
    for (int i = 0; i <= dly; i++) begin
      chk({tag, " req"}, mem_req, 1);
      chk({tag, " addr"}, mem_addr, ea);
      chk({tag, " be"}, mem_be, ebe);
      chk({tag, " wdata"}, mem_wdata, ed);
      chk({tag, " ready"}, store_ready, 0);
      chk({tag, " done"}, store_done, 0);
      if (i == dly) mem_ack = 1;
      @(negedge clk);
      mem_ack = 0;
    end
  endtask

  // at the cycle after the final ack: one done pulse, bus idle
  task automatic finish_chk(input string tag);
    chk({tag, " done"}, store_done, 1);
    chk({tag, " req off"}, mem_req, 0);
    chk({tag, " ready"}, store_ready, 1);
    chk({tag, " be idle"}, mem_be, 0);
    chk({tag, " wdata idle"}, mem_wdata, 0);
  endtask

  initial begin
    #2;
    chk("rst ready", store_ready, 1);
    chk("rst req", mem_req, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst be", mem_be, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst done", store_done, 0);
    chk("rst err", store_err, 0);
    @(negedge clk); rst_n = 1;
    mem_ack = 1;
    @(negedge clk); mem_ack = 0;
    chk("stray ack req", mem_req, 0);
    chk("stray ack done", store_done, 0);
    @(negedge clk);
    issue(6'd38, 64'h1003, 64'hFFFF_FFFF_FFFF_FFAB);
    beat("stb", 64'h1000, 8'h08, 64'h0000_0000_AB00_0000, 0);
    finish_chk("stb");
    @(negedge clk);
    chk("stb single done", store_done, 0);
    issue(6'd62, 64'h2000, 64'h1122_3344_5566_7788);
    beat("std", 64'h2000, 8'hFF, 64'h1122_3344_5566_7788, 0);
    finish_chk("std");
    issue(6'd36, 64'h2006, 64'h0000_0000_DEAD_BEEF);
    beat("stw b0", 64'h2000, 8'hC0, 64'hBEEF_0000_0000_0000, 1);
    beat("stw b1", 64'h2008, 8'h03, 64'h0000_0000_0000_DEAD, 0);
    finish_chk("stw");
    @(negedge clk);
    chk("stw single done", store_done, 0);
    issue(6'd62, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1122_3344_5566_7788);
    beat("wrap b0", 64'hFFFF_FFFF_FFFF_FFF8, 8'hC0, 64'h7788_0000_0000_0000, 0);
    beat("wrap b1", 64'h0, 8'h3F, 64'h0000_1122_3344_5566, 2);
    finish_chk("wrap");
    @(negedge clk);
    issue(6'd44, 64'h10, 64'hAAAA_AAAA_AAAA_1234);
    beat("sth", 64'h10, 8'h03, 64'h0000_0000_0000_1234, 3);
    finish_chk("sth");
    @(negedge clk);
    chk("sth single done", store_done, 0);
    issue(6'd31, 64'h40, 64'h55);
    chk("ill err", store_err, 1);
    chk("ill req", mem_req, 0);
    chk("ill ready", store_ready, 1);
    @(negedge clk);
    chk("ill err once", store_err, 0);
    chk("ill req later", mem_req, 0);
    chk("ill done", store_done, 0);
    issue(6'd36, 64'h2006, 64'h0000_0000_DEAD_BEEF);
    beat("rst b0", 64'h2000, 8'hC0, 64'hBEEF_0000_0000_0000, 0);
    chk("rst b1 pending", mem_req, 1);
    rst_n = 0;
    #1;
    chk("async req", mem_req, 0);
    chk("async be", mem_be, 0);
    chk("async ready", store_ready, 1);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      chk("abandon done", store_done, 0);
      chk("abandon req", mem_req, 0);
      chk("abandon ready", store_ready, 1);
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
